// File: rtl/layer_mac_array.sv
// Signed MAC array: one shared weight times a LANES-wide activation vector per term, summed over bursts ended by `last`.
// Optional MAC_SATURATE_EN: clamp each lane's sum to the ACC_SIZE bounds and report a per-lane sticky overflow flag.
module layer_mac_array #(
    parameter int LANES           = 5,
    parameter int VECTOR_SIZE     = 8,
    parameter int MULTIPLIER_SIZE = 8,
    parameter int ACC_SIZE        = 24,
    parameter int MUL_LATENCY     = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*VECTOR_SIZE-1:0]  vector_input,
    input  logic [MULTIPLIER_SIZE-1:0]    multiply_input,
    input  logic                          last,
    input  logic                          clear,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*ACC_SIZE-1:0]     accumulate_out,
    output logic [LANES-1:0]              overflow
);

    localparam int PW = VECTOR_SIZE + MULTIPLIER_SIZE;

    logic                         en;
    logic                         accept;
    logic                         acc_fire;

    logic [LANES*VECTOR_SIZE-1:0] vec_q, vec_d;
    logic [MULTIPLIER_SIZE-1:0]   wgt_q, wgt_d;
    logic                         s0_vld_q, s0_vld_d;
    logic                         s0_last_q, s0_last_d;

    logic [LANES*ACC_SIZE-1:0]    prod_q [MUL_LATENCY];
    logic [LANES*ACC_SIZE-1:0]    prod_d [MUL_LATENCY];
    logic [MUL_LATENCY-1:0]       prod_vld_q, prod_vld_d;
    logic [MUL_LATENCY-1:0]       prod_last_q, prod_last_d;

    logic [LANES*ACC_SIZE-1:0]    acc_q, acc_d;
    logic                         first_q, first_d;
    logic [LANES*ACC_SIZE-1:0]    out_q, out_d;
    logic                         out_vld_q, out_vld_d;

    logic [LANES*ACC_SIZE-1:0]    mul_w;
    logic [LANES*ACC_SIZE-1:0]    sum_w;

    function automatic logic [ACC_SIZE-1:0] mul_ext(
        input logic signed [VECTOR_SIZE-1:0]     a,
        input logic signed [MULTIPLIER_SIZE-1:0] b
    );
        logic signed [PW-1:0] p;
        p = PW'(a) * PW'(b);
        return {{(ACC_SIZE-PW){p[PW-1]}}, p};
    endfunction

`ifdef MAC_SATURATE_EN
    logic [LANES-1:0] lane_ovf;
    logic [LANES-1:0] ovf_run_q, ovf_run_d;
    logic [LANES-1:0] ovf_out_q, ovf_out_d;

    // One extra bit exposes signed overflow: the two top bits disagree.
    function automatic logic [ACC_SIZE-1:0] lane_add(
        input  logic [ACC_SIZE-1:0] a,
        input  logic [ACC_SIZE-1:0] p,
        output logic                ovf
    );
        logic [ACC_SIZE:0] wide;
        wide = {a[ACC_SIZE-1], a} + {p[ACC_SIZE-1], p};
        ovf  = wide[ACC_SIZE] ^ wide[ACC_SIZE-1];
        if (!ovf)
            return wide[ACC_SIZE-1:0];
        else if (wide[ACC_SIZE])
            return {1'b1, {(ACC_SIZE-1){1'b0}}};
        else
            return {1'b0, {(ACC_SIZE-1){1'b1}}};
    endfunction

    always_comb begin
        sum_w    = '0;
        lane_ovf = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_w[i*ACC_SIZE +: ACC_SIZE] = lane_add(
                first_q ? '0 : acc_q[i*ACC_SIZE +: ACC_SIZE],
                prod_q[MUL_LATENCY-1][i*ACC_SIZE +: ACC_SIZE],
                lane_ovf[i]);
        end
    end
`else
    always_comb begin
        sum_w = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_w[i*ACC_SIZE +: ACC_SIZE] =
                (first_q ? '0 : acc_q[i*ACC_SIZE +: ACC_SIZE]) +
                prod_q[MUL_LATENCY-1][i*ACC_SIZE +: ACC_SIZE];
        end
    end
`endif

    always_comb begin
        mul_w = '0;
        for (int i = 0; i < LANES; i++) begin
            mul_w[i*ACC_SIZE +: ACC_SIZE] =
                mul_ext(vec_q[i*VECTOR_SIZE +: VECTOR_SIZE], wgt_q);
        end
    end

    always_comb begin
        en       = !(out_vld_q && !out_ready);
        accept   = in_valid && en && !clear;
        acc_fire = en && prod_vld_q[MUL_LATENCY-1] && !clear;

        vec_d       = vec_q;
        wgt_d       = wgt_q;
        s0_vld_d    = s0_vld_q;
        s0_last_d   = s0_last_q;
        for (int s = 0; s < MUL_LATENCY; s++)
            prod_d[s] = prod_q[s];
        prod_vld_d  = prod_vld_q;
        prod_last_d = prod_last_q;
        acc_d       = acc_q;
        first_d     = first_q;
        out_d       = out_q;
        out_vld_d   = out_vld_q && !out_ready;

        if (en) begin
            s0_vld_d = accept;
            if (accept) begin
                vec_d     = vector_input;
                wgt_d     = multiply_input;
                s0_last_d = last;
            end
            prod_d[0]      = mul_w;
            prod_vld_d[0]  = s0_vld_q;
            prod_last_d[0] = s0_last_q;
            for (int s = 1; s < MUL_LATENCY; s++) begin
                prod_d[s]      = prod_q[s-1];
                prod_vld_d[s]  = prod_vld_q[s-1];
                prod_last_d[s] = prod_last_q[s-1];
            end
        end

        if (acc_fire) begin
            acc_d   = sum_w;
            first_d = prod_last_q[MUL_LATENCY-1];
            if (prod_last_q[MUL_LATENCY-1]) begin
                out_d     = sum_w;
                out_vld_d = 1'b1;
            end
        end

        // Flush pipeline and running sums; the held result is left alone.
        if (clear) begin
            s0_vld_d   = 1'b0;
            prod_vld_d = '0;
            acc_d      = '0;
            first_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vec_q       <= '0;
            wgt_q       <= '0;
            s0_vld_q    <= 1'b0;
            s0_last_q   <= 1'b0;
            for (int s = 0; s < MUL_LATENCY; s++)
                prod_q[s] <= '0;
            prod_vld_q  <= '0;
            prod_last_q <= '0;
            acc_q       <= '0;
            first_q     <= 1'b1;
            out_q       <= '0;
            out_vld_q   <= 1'b0;
        end else begin
            vec_q       <= vec_d;
            wgt_q       <= wgt_d;
            s0_vld_q    <= s0_vld_d;
            s0_last_q   <= s0_last_d;
            for (int s = 0; s < MUL_LATENCY; s++)
                prod_q[s] <= prod_d[s];
            prod_vld_q  <= prod_vld_d;
            prod_last_q <= prod_last_d;
            acc_q       <= acc_d;
            first_q     <= first_d;
            out_q       <= out_d;
            out_vld_q   <= out_vld_d;
        end
    end

`ifdef MAC_SATURATE_EN
    always_comb begin
        ovf_run_d = ovf_run_q;
        ovf_out_d = ovf_out_q;
        if (acc_fire) begin
            ovf_run_d = (first_q ? '0 : ovf_run_q) | lane_ovf;
            if (prod_last_q[MUL_LATENCY-1])
                ovf_out_d = ovf_run_d;
        end
        if (clear)
            ovf_run_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_run_q <= '0;
            ovf_out_q <= '0;
        end else begin
            ovf_run_q <= ovf_run_d;
            ovf_out_q <= ovf_out_d;
        end
    end

    assign overflow = ovf_out_q;
`else
    assign overflow = '0;
`endif

    assign in_ready       = en;
    assign out_valid      = out_vld_q;
    assign accumulate_out = out_q;

endmodule

// File: tb/tb_layer_mac_array.sv
// Directed bench for layer_mac_array: default instance plus a 17-bit accumulator instance for wrap/saturate.
module tb_layer_mac_array;
    localparam int LANES = 5;
    localparam int VS    = 8;
    localparam int MS    = 8;
    localparam int ACC   = 24;
    localparam int ACC17 = 17;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  last = 1'b0;
    logic                  clear = 1'b0;
    logic                  out_ready = 1'b1;
    logic [LANES*VS-1:0]   vector_input = '0;
    logic [MS-1:0]         multiply_input = '0;

    logic                  in_ready, out_valid;
    logic [LANES*ACC-1:0]  accumulate_out;
    logic [LANES-1:0]      overflow;
    logic                  in_ready17, out_valid17;
    logic [LANES*ACC17-1:0] acc_out17;
    logic [LANES-1:0]      overflow17;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    layer_mac_array dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .vector_input(vector_input), .multiply_input(multiply_input), .last(last),
        .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
        .accumulate_out(accumulate_out), .overflow(overflow)
    );

    layer_mac_array #(.ACC_SIZE(ACC17)) dut17 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready17),
        .vector_input(vector_input), .multiply_input(multiply_input), .last(last),
        .clear(clear), .out_valid(out_valid17), .out_ready(out_ready),
        .accumulate_out(acc_out17), .overflow(overflow17)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint lane24(input int i);
        logic [ACC-1:0] v;
        v = accumulate_out[i*ACC +: ACC];
        return longint'($signed(v));
    endfunction

    function automatic longint lane17(input int i);
        logic [ACC17-1:0] v;
        v = acc_out17[i*ACC17 +: ACC17];
        return longint'($signed(v));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lane0 = a0, lane1 = a1, lanes 2.. = ar
    task automatic set_term(input int w, input int a0, input int a1, input int ar, input logic lst);
        multiply_input = MS'(w);
        for (int i = 0; i < LANES; i++)
            vector_input[i*VS +: VS] = VS'((i == 0) ? a0 : ((i == 1) ? a1 : ar));
        last     = lst;
        in_valid = 1'b1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        last     = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            tick();
            seen = out_valid;
        end
        chk(tag, seen, 1);
    endtask

    initial begin
        repeat (2) tick();
        reset = 1'b1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_acc_out", accumulate_out, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_in_ready17", in_ready17, 1);
        tick();

        // weights 2,-3,4: lane0 10s -> 30, lane1 1s -> 3, lanes2-4 -5s -> -15
        set_term(2, 10, 1, -5, 1'b0); tick();
        set_term(-3, 10, 1, -5, 1'b0); tick();
        set_term(4, 10, 1, -5, 1'b1); tick();
        idle();
        tick(); tick();
        chk("lat_not_yet", out_valid, 0);
        tick();
        chk("lat_valid", out_valid, 1);
        chk("a_lane0", lane24(0), 30);
        chk("a_lane1", lane24(1), 3);
        chk("a_lane4", lane24(4), -15);
        tick();

        // -128 * -128
        set_term(-128, -128, -128, -128, 1'b1); tick();
        idle();
        wait_valid("b_wait");
        for (int i = 0; i < LANES; i++)
            chk($sformatf("b_lane%0d", i), lane24(i), 16384);
        tick();

        // stall with two terms of the next burst in flight
        out_ready = 1'b0;
        set_term(3, 4, 0, 0, 1'b1); tick();
        set_term(1, 5, 0, 0, 1'b0); tick();
        set_term(2, 6, 0, 0, 1'b1); tick();
        idle();
        tick();
        chk("c_stall_ready", in_ready, 0);
        repeat (3) tick();
        chk("c_hold_ready", in_ready, 0);
        chk("c_hold_valid", out_valid, 1);
        chk("c_hold_lane0", lane24(0), 12);
        out_ready = 1'b1;
        tick();
        chk("c_taken", out_valid, 0);
        wait_valid("c_wait");
        chk("c_lane0", lane24(0), 17);
        chk("c_lane1", lane24(1), 0);
        tick();

        // back-to-back: (5,5) then (7)
        set_term(1, 5, 0, 0, 1'b0); tick();
        set_term(1, 5, 0, 0, 1'b1); tick();
        set_term(1, 7, 0, 0, 1'b1); tick();
        idle();
        tick(); tick();
        chk("d_valid_a", out_valid, 1);
        chk("d_lane0_a", lane24(0), 10);
        tick();
        chk("d_valid_b", out_valid, 1);
        chk("d_lane0_b", lane24(0), 7);
        tick();
        chk("d_drop", out_valid, 0);

        // clear after two terms; term offered with clear is dropped
        set_term(1, 3, 0, 0, 1'b0); tick();
        set_term(1, 4, 0, 0, 1'b0); tick();
        idle();
        repeat (3) tick();
        clear = 1'b1;
        set_term(1, 100, 0, 0, 1'b1); tick();
        clear = 1'b0;
        idle();
        chk("e_hold_lane0", lane24(0), 7);
        repeat (5) tick();
        chk("e_no_result", out_valid, 0);
        set_term(1, 9, 0, 0, 1'b1); tick();
        idle();
        wait_valid("e_wait");
        chk("e_lane0", lane24(0), 9);
        tick();

        // reset mid-burst
        set_term(1, 50, 0, 0, 1'b0); tick();
        set_term(1, 60, 0, 0, 1'b0); tick();
        idle();
        tick();
        #2 reset = 1'b0;
        #1;
        chk("f_rst_lane0", lane24(0), 0);
        chk("f_rst_valid", out_valid, 0);
        chk("f_rst_ready", in_ready, 1);
        @(posedge clk);
        #1 reset = 1'b1;
        tick();
        set_term(3, 2, 2, 2, 1'b1); tick();
        idle();
        wait_valid("f_wait");
        chk("f_lane0", lane24(0), 6);
        chk("f_lane3", lane24(3), 6);
        tick();

        // five terms of 127*127 = 80645: fits 24 bits, exceeds 17-bit range
        repeat (4) begin
            set_term(127, 127, 127, 127, 1'b0); tick();
        end
        set_term(127, 127, 127, 127, 1'b1); tick();
        idle();
        wait_valid("g_wait");
        chk("g_lane0", lane24(0), 80645);
        chk("g_ovf", overflow, 0);
        chk("g17_valid", out_valid17, 1);
`ifdef MAC_SATURATE_EN
        chk("g17_lane0", lane17(0), 65535);
        chk("g17_lane4", lane17(4), 65535);
        chk("g17_ovf", overflow17, 31);
`else
        chk("g17_lane0", lane17(0), -50427);
        chk("g17_lane4", lane17(4), -50427);
        chk("g17_ovf", overflow17, 0);
`endif
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
